// File: rtl/shift_reg_universal.sv
// ============================================================================
// Module   : shift_reg_universal
// Brief    : Universal shift register with manual ops and counted shift bursts.
//            Optional rotate ops (ROL/ROR) enabled by defining SHIFT_REG_ROTATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CW-1:0]    cnt,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ASR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    remain;
    logic [2:0]       burst_op;
    logic [WIDTH-1:0] q_reg;
    logic             mode_can_burst;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            MODE_LOAD: res = din;
            MODE_SHL:  res = {cur[WIDTH-2:0], sl};
            MODE_SHR:  res = {sr, cur[WIDTH-1:1]};
            MODE_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
`ifdef SHIFT_REG_ROTATE_EN
            MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
`endif
            default:   res = cur;
        endcase
        return res;
    endfunction

    // HOLD/LOAD (and rotates when compiled out) fall through to manual handling.
    always_comb begin
        mode_can_burst = 1'b0;
        case (mode)
            MODE_SHL, MODE_SHR, MODE_ASR: mode_can_burst = 1'b1;
`ifdef SHIFT_REG_ROTATE_EN
            MODE_ROL, MODE_ROR:           mode_can_burst = 1'b1;
`endif
            default:                      mode_can_burst = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            remain   <= '0;
            burst_op <= MODE_HOLD;
            q_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && mode_can_burst) begin
                        burst_op <= mode;
                        remain   <= cnt;
                        state    <= (cnt == '0) ? DONE : RUN;
                    end else if (en) begin
                        q_reg <= apply_op(mode, q_reg, d, sin_l, sin_r);
                    end
                end
                RUN: begin
                    if (abort) begin
                        remain <= '0;
                        state  <= IDLE;
                    end else begin
                        q_reg  <= apply_op(burst_op, q_reg, d, sin_l, sin_r);
                        remain <= remain - 1'b1;
                        if (remain == CW'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign q      = q_reg;
    assign sout_l = q_reg[WIDTH-1];
    assign sout_r = q_reg[0];
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

endmodule

`default_nettype wire

// File: doc/shift_reg_universal.md
SHIFT_REG_UNIVERSAL -- requirements
Module: shift_reg_universal

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register width in bits (min 2).
REQ-002 SHALL have parameter CW, default 4, meaning width of the burst count input.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  enables a manual operation in IDLE.
REQ-006 SHALL have port mode  input  3  operation select: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ASR, 101 ROL, 110 ROR, 111 HOLD.
REQ-007 SHALL have port d  input  WIDTH  parallel load data.
REQ-008 SHALL have port sin_l  input  1  serial bit entering q[0] on SHL.
REQ-009 SHALL have port sin_r  input  1  serial bit entering q[WIDTH-1] on SHR.
REQ-010 SHALL have port start  input  1  requests a burst of cnt shifts.
REQ-011 SHALL have port cnt  input  CW  burst shift count.
REQ-012 SHALL have port abort  input  1  terminates a running burst.
REQ-013 SHALL have port q  output  WIDTH  registered parallel contents.
REQ-014 SHALL have port sout_l  output  1  equals q[WIDTH-1].
REQ-015 SHALL have port sout_r  output  1  equals q[0].
REQ-016 SHALL have port busy  output  1  high while in RUN.
REQ-017 SHALL have port done  output  1  registered one-cycle burst-complete pulse.

Function
REQ-018 Ops SHALL be: LOAD q<=d; SHL q<={q[W-2:0],sin_l}; SHR q<={sin_r,q[W-1:1]}; ASR q<={q[W-1],q[W-1:1]}; ROL q<={q[W-2:0],q[W-1]}; ROR q<={q[0],q[W-1:1]}; HOLD q unchanged.
REQ-019 FSM SHALL have states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-020 In IDLE with start=0 and en=1, the selected op SHALL execute once per edge; with en=0, q holds.
REQ-021 In IDLE, start=1 with a shift mode (010-110) SHALL win over en: on that edge latch mode and cnt, leave q unchanged, go to RUN (cnt>0) or DONE (cnt=0).
REQ-022 start=1 with mode 000, 001 or 111 SHALL be ignored; the cycle behaves as manual per REQ-020.
REQ-023 In RUN, each edge SHALL execute the latched op and decrement the remaining count; the edge taking it to 0 SHALL move to DONE. Burst of cnt=N thus completes N edges after start, with done high the following cycle.
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE; start is not accepted in DONE.
REQ-025 In RUN, en, mode, d, cnt and start SHALL be ignored; sin_l/sin_r SHALL be sampled live each shift.
REQ-026 abort=1 in RUN SHALL go to IDLE on that edge without shifting; q holds; no done pulse. abort SHALL be ignored outside RUN.
REQ-027 cnt greater than WIDTH SHALL be honoured (fill continues per op).

Reset
REQ-028 reset=0 SHALL immediately force q=0, state IDLE, remaining count 0, latched mode HOLD, busy=0, done=0, independent of clk.
REQ-029 reset asserted mid-burst SHALL abandon the burst with no done pulse; operation resumes on the first edge after reset=1.

Configuration
REQ-030 Macro SHIFT_REG_ROTATE_EN defined SHALL include ROL/ROR per REQ-018 for both manual and burst.
REQ-031 Without SHIFT_REG_ROTATE_EN, modes 101/110 SHALL act as HOLD and SHALL NOT start a burst; all other behaviour is unchanged.

Verification (WIDTH=8, CW=4)
REQ-032 reset=0 asserted mid-cycle with q=8'hFF and busy=1 -> q=8'h00, busy=0, done=0 before the next clk edge.
REQ-033 en=1 LOAD d=8'hA5 -> q=8'hA5; then SHL sin_l=1 -> 8'h4B; then SHR sin_r=0 -> 8'h25.
REQ-034 q=8'h96, en=1 ASR -> 8'hCB; with SHIFT_REG_ROTATE_EN, ROL -> 8'h97; without it, ROL -> 8'hCB unchanged.
REQ-035 q=8'h81, start=1, mode=ROR, cnt=3 (macro defined) -> busy high 3 cycles, q 8'hC0, 8'h60, 8'h30; done high one cycle after the third shift; en pulses during RUN have no effect.
REQ-036 q=8'hF0, start=1, SHL, sin_l=0, cnt=5; abort=1 on second RUN edge -> q=8'hE0, IDLE, no done pulse.
REQ-037 start=1 with cnt=0 -> done high exactly one cycle, busy never high, q unchanged.
